// File: rtl/ppu_px_fifo_mixer.sv
// PPU pixel FIFO with fine-X discard, DMG-style sprite overlay and palette mixing.
// The BG rows are stored in circular slots. The sprite overlay sits in parallel per-slot registers.
module ppu_px_fifo_mixer #(
  parameter int TILE_W = 8,
  parameter int BPP    = 2,
  parameter int DEPTH  = 16,
  localparam int PAL_W = BPP * (1 << BPP)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        line_start,
  input  logic [$clog2(TILE_W)-1:0]   fine_x,
  input  logic                        bg_push,
  input  logic [BPP*TILE_W-1:0]       bg_planes,
  output logic                        bg_ready,
  input  logic                        sp_load,
  input  logic [BPP*TILE_W-1:0]       sp_planes,
  input  logic [TILE_W-1:0]           sp_mask,
  input  logic                        sp_pri,
  input  logic                        sp_pal,
  input  logic                        pop_en,
  input  logic [PAL_W-1:0]            bgp,
  input  logic [PAL_W-1:0]            obp0,
  input  logic [PAL_W-1:0]            obp1,
  output logic [BPP-1:0]              px_out,
  output logic                        px_valid,
  output logic [$clog2(DEPTH+1)-1:0]  bg_count,
  output logic                        ovf,
  output logic                        sp_drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int XW = $clog2(TILE_W);
  localparam logic [CW-1:0] ROW_CNT  = CW'(TILE_W);
  localparam logic [CW-1:0] ROOM_MAX = CW'(DEPTH - TILE_W);

  typedef enum logic [1:0] {IDLE, DISCARD, RUN} state_t;

  state_t                        state;
  logic [XW-1:0]                 discard_cnt;
  logic [PW-1:0]                 rd_ptr;
  logic [PW-1:0]                 wr_ptr;
  logic [BPP-1:0]                bg_mem   [DEPTH];
  logic [BPP-1:0]                sp_col   [DEPTH];
  logic                          sp_pri_m [DEPTH];
  logic                          sp_pal_m [DEPTH];

  logic [TILE_W-1:0][BPP-1:0]    bg_row;
  logic [TILE_W-1:0][BPP-1:0]    sp_row;
  logic [TILE_W-1:0][PW-1:0]     wr_slot;
  logic [TILE_W-1:0][PW-1:0]     rd_slot;

  logic                          push_acc;
  logic                          load_acc;
  logic                          pop_acc;
  logic                          use_sp;
  logic [BPP-1:0]                head_bg;
  logic [BPP-1:0]                head_sp;
  logic [BPP-1:0]                mix_col;
  logic [BPP-1:0]                mix_px;
  logic [PAL_W-1:0]              mix_pal;

  // Row pixel i (i = 0 is leftmost) packs plane bits MSB-first, starting from plane BPP-1.
  for (genvar i = 0; i < TILE_W; i++) begin : g_px
    for (genvar p = 0; p < BPP; p++) begin : g_plane
      assign bg_row[i][p] = bg_planes[p*TILE_W + TILE_W-1-i];
      assign sp_row[i][p] = sp_planes[p*TILE_W + TILE_W-1-i];
    end
    assign wr_slot[i] = wr_ptr + PW'(i);
    assign rd_slot[i] = rd_ptr + PW'(i);
  end

  assign bg_ready = (bg_count <= ROOM_MAX);
  assign push_acc = bg_push && !line_start && bg_ready;
  assign load_acc = sp_load && !line_start && (bg_count >= ROW_CNT);
  assign pop_acc  = pop_en && !line_start && !sp_load && (bg_count != '0) && (state != IDLE);

  always_comb begin
    head_bg = bg_mem[rd_ptr];
    head_sp = sp_col[rd_ptr];
    use_sp  = (head_sp != '0) && !(sp_pri_m[rd_ptr] && (head_bg != '0));
    mix_pal = use_sp ? (sp_pal_m[rd_ptr] ? obp1 : obp0) : bgp;
    mix_col = use_sp ? head_sp : head_bg;
    mix_px  = BPP'(mix_pal >> (int'(mix_col) * BPP));
  end

  always_ff @(posedge clk) begin
    if (push_acc) begin
      for (int unsigned i = 0; i < TILE_W; i++) begin
        bg_mem[wr_slot[XW'(i)]] <= bg_row[XW'(i)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      discard_cnt <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      bg_count    <= '0;
      px_out      <= '0;
      px_valid    <= 1'b0;
      ovf         <= 1'b0;
      sp_drop     <= 1'b0;
      for (int unsigned s = 0; s < DEPTH; s++) begin
        sp_col[PW'(s)]   <= '0;
        sp_pri_m[PW'(s)] <= 1'b0;
        sp_pal_m[PW'(s)] <= 1'b0;
      end
    end else begin
      ovf      <= bg_push && !line_start && !bg_ready;
      sp_drop  <= sp_load && !line_start && (bg_count < ROW_CNT);
      px_valid <= 1'b0;
      if (line_start) begin
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        bg_count    <= '0;
        discard_cnt <= fine_x;
        state       <= (fine_x != '0) ? DISCARD : RUN;
        for (int unsigned s = 0; s < DEPTH; s++) begin
          sp_col[PW'(s)]   <= '0;
          sp_pri_m[PW'(s)] <= 1'b0;
          sp_pal_m[PW'(s)] <= 1'b0;
        end
      end else begin
        if (push_acc) begin
          wr_ptr <= wr_ptr + PW'(TILE_W);
        end
        // A slot accepts a sprite pixel only while its stored sprite colour is still transparent.
        if (load_acc) begin
          for (int unsigned i = 0; i < TILE_W; i++) begin
            if (sp_mask[XW'(TILE_W-1-i)] && (sp_col[rd_slot[XW'(i)]] == '0)) begin
              sp_col[rd_slot[XW'(i)]]   <= sp_row[XW'(i)];
              sp_pri_m[rd_slot[XW'(i)]] <= sp_pri;
              sp_pal_m[rd_slot[XW'(i)]] <= sp_pal;
            end
          end
        end
        if (pop_acc) begin
          rd_ptr           <= rd_ptr + PW'(1);
          sp_col[rd_ptr]   <= '0;
          sp_pri_m[rd_ptr] <= 1'b0;
          sp_pal_m[rd_ptr] <= 1'b0;
          if (state == DISCARD) begin
            discard_cnt <= discard_cnt - XW'(1);
            if (discard_cnt == XW'(1)) begin
              state <= RUN;
            end
          end else begin
            px_valid <= 1'b1;
            px_out   <= mix_px;
          end
        end
        bg_count <= bg_count + (push_acc ? ROW_CNT : '0) - CW'(pop_acc);
      end
    end
  end

endmodule
